// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial bit-pattern detector.
// The active pattern, length and overlap mode are latched through a config
// strobe. The detector keeps a short history of qualified input bits and
// compares the newest 'len' bits (history plus the bit on xin this cycle)
// against the low 'len' bits of the active pattern. Matches are counted in a
// saturating counter. With the reset defaults it behaves like the legacy
// overlapping "101" detector.

module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter bit                 REG_OUT     = 1'b0,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(3'b101),
  parameter int                 RST_LEN     = 3,
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               xin,
  input  logic               xin_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap_in,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count
);

  // A reset length larger than the history would never match; clamp it the
  // same way a runtime length is clamped.
  localparam int               RST_LEN_C = (RST_LEN > MAX_LEN) ? MAX_LEN : RST_LEN;
  localparam logic [LEN_W-1:0] RST_LEN_V = LEN_W'(RST_LEN_C);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Active configuration
  logic [MAX_LEN-1:0] act_pattern;
  logic [LEN_W-1:0]   act_len;
  logic               act_overlap;

  // Bit history. Only MAX_LEN-1 past bits are kept: together with the bit on
  // xin they form a full MAX_LEN-bit comparison window, and anything older
  // can never take part in a match.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic               fill_ok;
  logic               match;

  // Clamp an over-long programmed length to the history depth
  always_comb begin
    len_clamped = len_in;
    if (len_in > MAX_LEN_V) begin
      len_clamped = MAX_LEN_V;
    end
  end

  // Comparison window: newest bit (xin) in the LSB, older history above it
  always_comb begin
    window = {hist, xin};
  end

  // Mask selecting the low act_len bits of window and pattern
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(act_len));
    end
  end

  // A match needs len-1 valid history bits plus the current valid bit, a
  // non-zero length, and no config load in progress this cycle
  always_comb begin
    fill_ok = ({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, act_len};
    match   = xin_valid && !cfg_load && (act_len != '0) && fill_ok &&
              (((window ^ act_pattern) & len_mask) == '0);
  end

  // Active configuration registers, reloaded by the config strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_pattern <= RST_PATTERN;
      act_len     <= RST_LEN_V;
      act_overlap <= RST_OVERLAP;
    end else if (cfg_load) begin
      act_pattern <= pattern_in;
      act_len     <= len_clamped;
      act_overlap <= overlap_in;
    end
  end

  // Shift qualified bits into the history; a config load or a non-overlapping
  // match restarts the fill count so old bits cannot start the next match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (cfg_load) begin
      hist <= '0;
      fill <= '0;
    end else if (xin_valid) begin
      hist <= window[MAX_LEN-2:0];
      if (match && !act_overlap) begin
        fill <= '0;
      end else if (fill != MAX_LEN_V) begin
        fill <= fill + LEN_W'(1);
      end
    end
  end

  // Saturating match counter; a clear request beats a coincident match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= '0;
    end else if (match && (match_count != CNT_MAX)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  // Output either the same-cycle match or a one-cycle-delayed copy of it
  if (REG_OUT) begin : g_reg_y
    logic y_q;

    // Registered match pulse; match is low during a config load, so the
    // register clears itself on the edge of a load
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        y_q <= 1'b0;
      end else begin
        y_q <= match;
      end
    end

    assign y = y_q;
  end else begin : g_comb_y
    assign y = match;
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed bench for seq_detect_prog. Three instances
// share the stimulus: the default combinational-output build, a registered
// output build and a 2-bit counter build. A bit-queue model of the detector
// is checked against all of them on every clock, and directed streams carry
// hand-computed expectations from the test plan.

module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk        = 1'b0;
  logic               reset      = 1'b1;
  logic               xin        = 1'b0;
  logic               xin_valid  = 1'b0;
  logic               cfg_load   = 1'b0;
  logic [MAX_LEN-1:0] pattern_in = '0;
  logic [LEN_W-1:0]   len_in     = '0;
  logic               overlap_in = 1'b0;
  logic               cnt_clr    = 1'b0;

  logic       y_c, y_r, y_s;
  logic [7:0] cnt_c, cnt_r;
  logic [1:0] cnt_s;

  int vectors     = 0;
  int miscompares = 0;

  logic last_y    = 1'b0;
  logic last_yreg = 1'b0;

  // Model state: the valid bits that may still take part in a match
  bit         m_hist[$];
  logic [7:0] m_pat  = 8'h05;
  int         m_len  = 3;
  bit         m_ovl  = 1'b1;
  int         m_cnt8 = 0;
  int         m_cnt2 = 0;
  bit         m_yreg = 1'b0;
  bit         exp_match;

  // Free-running clock
  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8), .REG_OUT(1'b0)) dut (
    .clk(clk), .reset(reset), .xin(xin), .xin_valid(xin_valid),
    .cfg_load(cfg_load), .pattern_in(pattern_in), .len_in(len_in),
    .overlap_in(overlap_in), .cnt_clr(cnt_clr), .y(y_c), .match_count(cnt_c)
  );

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8), .REG_OUT(1'b1)) dut_reg (
    .clk(clk), .reset(reset), .xin(xin), .xin_valid(xin_valid),
    .cfg_load(cfg_load), .pattern_in(pattern_in), .len_in(len_in),
    .overlap_in(overlap_in), .cnt_clr(cnt_clr), .y(y_r), .match_count(cnt_r)
  );

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2), .REG_OUT(1'b0)) dut_small (
    .clk(clk), .reset(reset), .xin(xin), .xin_valid(xin_valid),
    .cfg_load(cfg_load), .pattern_in(pattern_in), .len_in(len_in),
    .overlap_in(overlap_in), .cnt_clr(cnt_clr), .y(y_s), .match_count(cnt_s)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Pattern rule: the newest len valid bits, oldest first, spell
  // pattern[len-1] .. pattern[0]
  function automatic bit model_match();
    int n;
    n = m_hist.size();
    if (!xin_valid || cfg_load || m_len == 0) return 1'b0;
    if (n + 1 < m_len) return 1'b0;
    if (xin != m_pat[0]) return 1'b0;
    for (int k = 1; k < m_len; k++) begin
      if (m_hist[n - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Compare process: check every instance against the model on each falling
  // edge, then advance the model to what the next rising edge will do
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_hist.delete();
        m_pat  = 8'h05;
        m_len  = 3;
        m_ovl  = 1'b1;
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_yreg = 1'b0;
      end
      exp_match = model_match();
      checkOutput("model_y_comb",  int'(y_c),   int'(exp_match));
      checkOutput("model_y_small", int'(y_s),   int'(exp_match));
      checkOutput("model_y_reg",   int'(y_r),   int'(m_yreg));
      checkOutput("model_cnt",     int'(cnt_c), m_cnt8);
      checkOutput("model_cnt_reg", int'(cnt_r), m_cnt8);
      checkOutput("model_cnt_2b",  int'(cnt_s), m_cnt2);
      if (reset) begin
        m_yreg = exp_match;
        if (cnt_clr) begin
          m_cnt8 = 0;
          m_cnt2 = 0;
        end else if (exp_match) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3)   m_cnt2++;
        end
        if (cfg_load) begin
          m_pat = pattern_in;
          m_len = (int'(len_in) > MAX_LEN) ? MAX_LEN : int'(len_in);
          m_ovl = overlap_in;
          m_hist.delete();
        end else if (xin_valid) begin
          if (exp_match && !m_ovl) begin
            m_hist.delete();
          end else begin
            m_hist.push_back(xin);
            if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
          end
        end
      end
    end
  end

  // One clock with the given inputs; outputs captured after the falling edge
  task automatic applyStimulus(input logic v, input logic x, input logic clr);
    xin_valid = v;
    xin       = x;
    cnt_clr   = clr;
    @(negedge clk);
    #1;
    last_y    = y_c;
    last_yreg = y_r;
    @(posedge clk);
    #1;
    xin_valid = 1'b0;
    xin       = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  // Config strobe, optionally with a bit on xin that must be discarded
  task automatic loadConfig(input logic [7:0] pat, input logic [3:0] len,
                            input logic ovl, input logic v, input logic x);
    cfg_load   = 1'b1;
    pattern_in = pat;
    len_in     = len;
    overlap_in = ovl;
    xin_valid  = v;
    xin        = x;
    @(negedge clk);
    #1;
    last_y = y_c;
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
    xin_valid = 1'b0;
    xin       = 1'b0;
  endtask

  // Hold reset low across a full clock, optionally with a bit on xin
  task automatic doReset(input logic v, input logic x);
    reset     = 1'b0;
    xin_valid = v;
    xin       = x;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    xin_valid = 1'b0;
    xin       = 1'b0;
  endtask

  // Stream n valid bits, first bit in bits[n-1]; expy gives y per bit in the
  // same order. With gap set an invalid cycle follows each bit and y must stay low.
  task automatic runStream(input string tag, input int n, input logic [15:0] bits,
                           input logic [15:0] expy, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b1, bits[i], 1'b0);
      checkOutput($sformatf("%s_y_bit%0d", tag, n - i), int'(last_y), int'(expy[i]));
      if (gap) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput($sformatf("%s_y_gap%0d", tag, n - i), int'(last_y), 0);
      end
    end
  endtask

  // Directed test sequence
  initial begin
    #1;
    doReset(1'b0, 1'b0);
    checkOutput("reset_cnt", int'(cnt_c), 0);
    checkOutput("reset_yreg", int'(y_r), 0);

    // Defaults: overlapping 101
    runStream("t1", 5, 16'b10101, 16'b00101, 1'b0);
    checkOutput("t1_cnt", int'(cnt_c), 2);

    // Non-overlapping 101; count survives the config load
    loadConfig(8'h05, 4'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_cnt_kept", int'(cnt_c), 2);
    runStream("t2", 7, 16'b1010101, 16'b0010001, 1'b0);
    checkOutput("t2_cnt", int'(cnt_c), 4);

    // Full-length pattern with gaps, then length 0, then over-long length
    loadConfig(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
    runStream("t3", 8, 16'h00A5, 16'h0001, 1'b1);
    checkOutput("t3_cnt", int'(cnt_c), 5);
    loadConfig(8'hA5, 4'd0, 1'b1, 1'b0, 1'b0);
    runStream("t3_len0", 8, 16'h00A5, 16'h0000, 1'b1);
    checkOutput("t3_len0_cnt", int'(cnt_c), 5);
    loadConfig(8'hA5, 4'd12, 1'b1, 1'b0, 1'b0);
    runStream("t3_len12", 8, 16'h00A5, 16'h0001, 1'b1);
    checkOutput("t3_len12_cnt", int'(cnt_c), 6);

    // Length 1: every bit equal to pattern[0] matches
    loadConfig(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    runStream("len1", 3, 16'b110, 16'b110, 1'b0);
    checkOutput("len1_cnt", int'(cnt_c), 8);

    // Registered output: one-cycle pulse after the final bit
    doReset(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4_yreg_b1", int'(last_yreg), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4_yreg_b2", int'(last_yreg), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4_yreg_b3", int'(last_yreg), 0);
    checkOutput("t4_ycomb_b3", int'(last_y), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t4_yreg_after", int'(last_yreg), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t4_yreg_after2", int'(last_yreg), 0);

    // Config load discards history and the coincident bit
    doReset(1'b0, 1'b0);
    runStream("t5a_pre", 2, 16'b10, 16'b00, 1'b0);
    loadConfig(8'h05, 4'd3, 1'b1, 1'b1, 1'b1);
    checkOutput("t5a_cfg_y", int'(last_y), 0);
    runStream("t5a", 3, 16'b101, 16'b001, 1'b0);

    // Same with a reset pulse instead of the config load
    doReset(1'b0, 1'b0);
    runStream("t5b_pre", 2, 16'b10, 16'b00, 1'b0);
    doReset(1'b1, 1'b1);
    runStream("t5b", 3, 16'b101, 16'b001, 1'b0);

    // 2-bit counter saturates at 3; clear beats a coincident match
    doReset(1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, (i % 2 == 1) ? 1'b1 : 1'b0, 1'b0);
      if (i == 3) checkOutput("t6_cnt_b3", int'(cnt_s), 1);
      if (i == 5) checkOutput("t6_cnt_b5", int'(cnt_s), 2);
      if (i == 7) checkOutput("t6_cnt_b7", int'(cnt_s), 3);
      if (i == 9) checkOutput("t6_cnt_b9", int'(cnt_s), 3);
    end
    checkOutput("t6_cnt8", int'(cnt_c), 4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t6_clr_y", int'(last_y), 1);
    checkOutput("t6_clr_cnt2", int'(cnt_s), 0);
    checkOutput("t6_clr_cnt8", int'(cnt_c), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
